ifu_fetch_ctrl: RTL and testbench

//  Instruction-fetch controller; the initiator side of the EXU op_en/ex_end handshake.
//  - Fetches the 32-bit word at pc from the instruction memory port.
//  - Pulses op_en for one cycle, then waits for the EXU's ex_end toggle.
//  - Loads next_pc and repeats. Stops on ebreak, misaligned pc or fetch timeout.

---
 rtl/ifu_fetch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: fetches at pc, issues op_en, waits for the EXU ex_end toggle.
// Define IFU_PERF_CNT_EN to build the instret / cycle_cnt performance counters.
module ifu_fetch_ctrl #(
   parameter logic [31:0] RESET_PC       = 32'h8000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned TO_W           = 11
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        o_ifetch_req,
   output logic [31:0] o_ifetch_addr,
   input  logic        i_ifetch_ready,
   input  logic        i_ifetch_rvalid,
   input  logic [31:0] i_ifetch_rdata,
   output logic [31:0] o_op,
   output logic        o_op_en,
   output logic [31:0] o_pc,
   input  logic        i_ex_end,
   input  logic [31:0] i_next_pc,
   input  logic        i_ebreak_flag,
   output logic        o_halted,
   output logic [1:0]  o_fetch_err,
   output logic [63:0] o_instret,
   output logic [63:0] o_cycle_cnt
);

   typedef enum logic [2:0] {
      StFetchReq,
      StFetchWait,
      StIssue,
      StExecWait,
      StHalt,
      StError
   } state_e;

   state_e          r_state;
   state_e          w_state_d;
   logic            r_ifetch_req;
   logic            r_ex_end_q;
   logic            r_halted;
   logic [1:0]      r_fetch_err;
   logic [31:0]     r_pc;
   logic [31:0]     r_op;
   logic [TO_W-1:0] r_to_cnt;

   logic            w_accept;
   logic            w_ex_edge;
   logic            w_misaligned;
   logic            w_timeout;
   logic            w_capture;
   logic            w_running;

   // r_ifetch_req is only ever high while in StFetchReq, so it qualifies the handshake.
   assign w_accept     = r_ifetch_req & i_ifetch_ready;
   assign w_ex_edge    = (r_state == StExecWait) && (i_ex_end != r_ex_end_q);
   assign w_misaligned = (i_next_pc[1:0] != 2'b00);
   assign w_timeout    = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign w_capture    = (r_state == StFetchWait) && i_ifetch_rvalid;
   assign w_running    = (r_state != StHalt) && (r_state != StError);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StFetchReq;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StFetchReq: begin
            if (w_accept) w_state_d = StFetchWait;
         end
         StFetchWait: begin
            if (i_ifetch_rvalid) begin
               w_state_d = StIssue;
            end else if (w_timeout) begin
               w_state_d = StError;
            end
         end
         StIssue: begin
            w_state_d = StExecWait;
         end
         StExecWait: begin
            if (w_ex_edge) begin
               if (i_ebreak_flag) begin
                  w_state_d = StHalt;
               end else if (w_misaligned) begin
                  w_state_d = StError;
               end else begin
                  w_state_d = StFetchReq;
               end
            end
         end
         StHalt, StError: begin
            w_state_d = r_state;
         end
         default: begin
            w_state_d = StError;
         end
      endcase
   end

   always_comb begin
      o_ifetch_req = r_ifetch_req;
      o_op_en      = (r_state == StIssue);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ifetch_req <= 1'b0;
         r_ex_end_q   <= 1'b0;
         r_halted     <= 1'b0;
         r_fetch_err  <= 2'b00;
         r_pc         <= RESET_PC;
         r_op         <= 32'h0;
         r_to_cnt     <= '0;
      end else begin
         r_ex_end_q   <= i_ex_end;
         r_ifetch_req <= (w_state_d == StFetchReq);
         if (w_accept) begin
            r_to_cnt <= '0;
         end else if (r_state == StFetchWait) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end
         if (w_capture) begin
            r_op <= i_ifetch_rdata;
         end
         if ((r_state == StFetchWait) && !i_ifetch_rvalid && w_timeout) begin
            r_fetch_err <= 2'b10;
         end
         // ebreak wins over a misaligned target; a rejected target leaves pc untouched.
         if (w_ex_edge) begin
            if (i_ebreak_flag) begin
               r_halted <= 1'b1;
            end else if (w_misaligned) begin
               r_fetch_err <= 2'b01;
            end else begin
               r_pc <= i_next_pc;
            end
         end
      end
   end

   assign o_ifetch_addr = r_pc;
   assign o_pc          = r_pc;
   assign o_op          = r_op;
   assign o_halted      = r_halted;
   assign o_fetch_err   = r_fetch_err;

`ifdef IFU_PERF_CNT_EN
   logic [63:0] r_instret;
   logic [63:0] r_cycle_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instret   <= 64'd0;
         r_cycle_cnt <= 64'd0;
      end else if (w_running) begin
         r_cycle_cnt <= r_cycle_cnt + 64'd1;
         if (w_ex_edge) begin
            r_instret <= r_instret + 64'd1;
         end
      end
   end

   assign o_instret   = r_instret;
   assign o_cycle_cnt = r_cycle_cnt;
`else
   assign o_instret   = 64'd0;
   assign o_cycle_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: randomized memory/EXU behaviour against a
// transaction-level model of the expected pc stream, handshake timing and counters.
module tb_ifu_fetch_ctrl;

   localparam logic [31:0] ResetPc = 32'h8000_0000;
   localparam int unsigned TimeoutCycles = 1024;
`ifdef IFU_PERF_CNT_EN
   localparam logic [63:0] PerfMask = '1;
`else
   localparam logic [63:0] PerfMask = '0;
`endif

   logic        clk;
   logic        rst_n;
   logic        ifetch_req;
   logic [31:0] ifetch_addr;
   logic        ifetch_ready;
   logic        ifetch_rvalid;
   logic [31:0] ifetch_rdata;
   logic [31:0] op;
   logic        op_en;
   logic [31:0] pc;
   logic        ex_end;
   logic [31:0] next_pc;
   logic        ebreak_flag;
   logic        halted;
   logic [1:0]  fetch_err;
   logic [63:0] instret;
   logic [63:0] cycle_cnt;

   int          n_tests;
   int          n_fail;
   logic [31:0] exp_pc;
   logic [63:0] exp_instret;
   logic [63:0] cyc;
   logic        stopped;

   ifu_fetch_ctrl #(
      .RESET_PC       (ResetPc),
      .TIMEOUT_CYCLES (TimeoutCycles),
      .TO_W           (11)
   ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .o_ifetch_req    (ifetch_req),
      .o_ifetch_addr   (ifetch_addr),
      .i_ifetch_ready  (ifetch_ready),
      .i_ifetch_rvalid (ifetch_rvalid),
      .i_ifetch_rdata  (ifetch_rdata),
      .o_op            (op),
      .o_op_en         (op_en),
      .o_pc            (pc),
      .i_ex_end        (ex_end),
      .i_next_pc       (next_pc),
      .i_ebreak_flag   (ebreak_flag),
      .o_halted        (halted),
      .o_fetch_err     (fetch_err),
      .o_instret       (instret),
      .o_cycle_cnt     (cycle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles since reset release, as seen by the bench.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 64'd0;
      else        cyc <= cyc + 64'd1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] perf(input logic [63:0] v);
      return v & PerfMask;
   endfunction

   task automatic do_reset();
      rst_n         = 1'b0;
      ifetch_ready  = 1'b0;
      ifetch_rvalid = 1'b0;
      ifetch_rdata  = 32'h0;
      ex_end        = 1'b0;
      next_pc       = 32'h0;
      ebreak_flag   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req", ifetch_req, 1'b0);
      check("rst_open", op_en, 1'b0);
      check("rst_pc", pc, ResetPc);
      check("rst_op", op, 32'h0);
      check("rst_halted", halted, 1'b0);
      check("rst_err", fetch_err, 2'b00);
      check("rst_instret", instret, 64'd0);
      check("rst_cycle", cycle_cnt, 64'd0);
      rst_n       = 1'b1;
      exp_pc      = ResetPc;
      exp_instret = 64'd0;
      stopped     = 1'b0;
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!ifetch_req && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("req_up", ifetch_req, 1'b1);
   endtask

   // One full instruction: request, optional stall, fetch latency, issue, execute, ex_end edge.
   task automatic run_instr(input int hold, input int rdly, input int edly,
                            input logic [31:0] word, input logic [31:0] npc,
                            input logic ebrk, input logic early_rv, input logic stray);
      wait_req();
      if (!ifetch_req) begin
         stopped = 1'b1;
         return;
      end
      check("req_addr", ifetch_addr, exp_pc);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("stall_req", ifetch_req, 1'b1);
         check("stall_addr", ifetch_addr, exp_pc);
         check("stall_open", op_en, 1'b0);
      end
      ifetch_ready = 1'b1;
      if (early_rv) begin
         ifetch_rvalid = 1'b1;
         ifetch_rdata  = ~word;
      end
      @(negedge clk);
      ifetch_ready  = 1'b0;
      ifetch_rvalid = 1'b0;
      if (stray) ex_end = ~ex_end;
      check("req_drop", ifetch_req, 1'b0);
      for (int i = 0; i < rdly; i++) begin
         @(negedge clk);
         check("wait_open", op_en, 1'b0);
      end
      ifetch_rvalid = 1'b1;
      ifetch_rdata  = word;
      @(negedge clk);
      ifetch_rvalid = 1'b0;
      ifetch_rdata  = $urandom;
      check("issue_open", op_en, 1'b1);
      check("issue_op", op, word);
      check("issue_pc", pc, exp_pc);
      @(negedge clk);
      check("open_pulse", op_en, 1'b0);
      for (int i = 0; i < edly; i++) begin
         @(negedge clk);
         check("exec_open", op_en, 1'b0);
         check("exec_op", op, word);
         check("exec_pc", pc, exp_pc);
      end
      next_pc     = npc;
      ebreak_flag = ebrk;
      ex_end      = ~ex_end;
      @(negedge clk);
      ebreak_flag = 1'b0;
      exp_instret = exp_instret + 64'd1;
      if (ebrk) begin
         check("ebrk_halted", halted, 1'b1);
         check("ebrk_err", fetch_err, 2'b00);
         check("ebrk_req", ifetch_req, 1'b0);
         stopped = 1'b1;
      end else if (npc[1:0] != 2'b00) begin
         check("mis_err", fetch_err, 2'b01);
         check("mis_pc", pc, exp_pc);
         check("mis_halted", halted, 1'b0);
         check("mis_req", ifetch_req, 1'b0);
         stopped = 1'b1;
      end else begin
         exp_pc = npc;
         check("next_req", ifetch_req, 1'b1);
         check("next_addr", ifetch_addr, npc);
         check("next_pc", pc, npc);
      end
      check("instret", instret, perf(exp_instret));
      check("cycle_cnt", cycle_cnt, perf(cyc));
   endtask

   // After a terminal event: tempt the DUT with traffic and confirm nothing moves.
   task automatic check_frozen(input int n);
      logic [63:0] frz;
      frz = cyc;
      check("frz_cycle0", cycle_cnt, perf(frz));
      ifetch_ready  = 1'b1;
      ifetch_rvalid = 1'b1;
      for (int i = 0; i < n; i++) begin
         ex_end = ~ex_end;
         @(negedge clk);
         check("term_req", ifetch_req, 1'b0);
         check("term_open", op_en, 1'b0);
      end
      check("frz_instret", instret, perf(exp_instret));
      check("frz_cycle", cycle_cnt, perf(frz));
      ifetch_ready  = 1'b0;
      ifetch_rvalid = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      @(negedge clk);
      do_reset();

      // Best-case first instruction, then two more sequential ones.
      run_instr(0, 0, 0, 32'h0010_0093, 32'h8000_0004, 1'b0, 1'b0, 1'b0);
      run_instr(0, 1, 1, $urandom, 32'h8000_0008, 1'b0, 1'b0, 1'b0);
      run_instr(0, 0, 2, $urandom, 32'h8000_000C, 1'b0, 1'b0, 1'b0);
      check("instret3", instret, perf(64'd3));

      run_instr(5, 0, 0, $urandom, 32'h8000_0010, 1'b0, 1'b0, 1'b0);
      run_instr(0, 0, 0, $urandom, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);

      for (int k = 0; k < 30 && !stopped; k++) begin
         run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom, $urandom & 32'hFFFF_FFFC, 1'b0,
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end

      run_instr(1, 0, 1, $urandom, 32'h8000_0102, 1'b0, 1'b0, 1'b0);
      check_frozen(8);

      do_reset();
      run_instr(0, 2, 0, $urandom, 32'h8000_0004, 1'b0, 1'b0, 1'b0);
      run_instr(0, 0, 0, 32'h0010_0073, 32'h8000_0006, 1'b1, 1'b0, 1'b0);
      check_frozen(8);

      // Fetch timeout: rvalid never arrives.
      do_reset();
      wait_req();
      ifetch_ready = 1'b1;
      @(negedge clk);
      ifetch_ready = 1'b0;
      repeat (TimeoutCycles - 1) @(negedge clk);
      check("to_before", fetch_err, 2'b00);
      @(negedge clk);
      check("to_err", fetch_err, 2'b10);
      check("to_req", ifetch_req, 1'b0);
      check_frozen(8);

      // Reset in the middle of a fetch abandons it.
      do_reset();
      run_instr(0, 0, 0, 32'hDEAD_BEEF, 32'h8000_0040, 1'b0, 1'b0, 1'b0);
      wait_req();
      ifetch_ready = 1'b1;
      @(negedge clk);
      ifetch_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_pc", pc, ResetPc);
      check("mid_open", op_en, 1'b0);
      check("mid_req", ifetch_req, 1'b0);
      check("mid_op", op, 32'h0);
      @(negedge clk);
      do_reset();
      run_instr(0, 0, 0, $urandom, 32'h8000_0004, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
